mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 15 +
 rtl/mem_responder_if.sv | 35 +++
 rtl/mem_delay_pipe.sv | 32 +++
 rtl/mem_responder.sv | 83 ++++++++
 tb/tb_mem_responder.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared widths, default read latency and the pipeline stage record for mem_responder.
package mem_pkg;

  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;
  localparam int DEFAULT_LATENCY = 4;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              err;
  } stage_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle of mem_responder; align_err exists only with MEM_RESP_ALIGN_CHECK_EN.
interface mem_responder_if;
  import mem_pkg::*;

  logic              enable;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [ADDR_W-1:0] resp_addr;
  logic              busy;
`ifdef MEM_RESP_ALIGN_CHECK_EN
  logic              align_err;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, resp_addr, busy, align_err
  );
  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, resp_addr, busy, align_err
  );
`else
  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, resp_addr, busy
  );
  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, resp_addr, busy
  );
`endif

endinterface

// File: rtl/mem_delay_pipe.sv
// LATENCY-deep shift register of read stages; shifts every cycle, cleared by synchronous reset.
module mem_delay_pipe
  import mem_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic   clk,
  input  logic   rst,
  input  stage_t stage_in,
  output stage_t stage_out,
  output logic   any_valid
);

  stage_t stages [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) stages[i] <= '0;
    end else begin
      stages[0] <= stage_in;
      for (int i = 1; i < LATENCY; i++) stages[i] <= stages[i-1];
    end
  end

  assign stage_out = stages[LATENCY-1];

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < LATENCY; i++) any_valid = any_valid | stages[i].valid;
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency 16-bit word memory responder; reads return LATENCY cycles after accept.
// Optional MEM_RESP_ALIGN_CHECK_EN flags odd-byte reads and drops odd-byte writes.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = DEFAULT_LATENCY
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic              misaligned;
  logic              wr_accept;
  logic              rd_accept;
  stage_t            pipe_in;
  stage_t            pipe_out;
  logic              pipe_busy;

  // Byte address to word index; bits above the array size wrap.
  assign idx    = bus.addr[IDX_W:1];
  assign accept = bus.enable & ~rst;

`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign misaligned = bus.addr[0];
`else
  assign misaligned = 1'b0;
`endif

  assign wr_accept = accept & bus.wr & ~misaligned;
  assign rd_accept = accept & ~bus.wr;

  // The array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[idx] <= bus.data_in;
  end

  always_comb begin
    pipe_in = '0;
    if (rd_accept) begin
      pipe_in.valid = 1'b1;
      pipe_in.data  = mem[idx];
      pipe_in.addr  = bus.addr;
      pipe_in.err   = misaligned;
    end
  end

  mem_delay_pipe #(
    .LATENCY (LATENCY)
  ) u_delay_pipe (
    .clk       (clk),
    .rst       (rst),
    .stage_in  (pipe_in),
    .stage_out (pipe_out),
    .any_valid (pipe_busy)
  );

  assign bus.data_valid = pipe_out.valid;
  assign bus.data_out   = pipe_out.valid ? pipe_out.data : '0;
  assign bus.resp_addr  = pipe_out.valid ? pipe_out.addr : '0;
  assign bus.busy       = pipe_busy;

`ifdef MEM_RESP_ALIGN_CHECK_EN
  logic wr_err_q;

  always_ff @(posedge clk) begin
    if (rst) wr_err_q <= 1'b0;
    else     wr_err_q <= accept & bus.wr & misaligned;
  end

  assign bus.align_err = (pipe_out.valid & pipe_out.err) | wr_err_q;
`else
  logic unused_err;
  assign unused_err = pipe_out.err;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (DEPTH_WORDS=1024, LATENCY=4).
module tb_mem_responder;
  import mem_pkg::*;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;
  int   pulses;

  mem_responder_if bus_if ();

  mem_responder #(
    .DEPTH_WORDS (1024),
    .LATENCY     (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    bus_if.enable  = 1'b1;
    bus_if.wr      = 1'b1;
    bus_if.addr    = a;
    bus_if.data_in = d;
    @(posedge clk); #1;
    bus_if.enable  = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a);
    bus_if.enable = 1'b1;
    bus_if.wr     = 1'b0;
    bus_if.addr   = a;
    @(posedge clk); #1;
    bus_if.enable = 1'b0;
  endtask

  // Single read, checks silence until the return cycle, the returned word, then silence again.
  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    do_read(a);
    chk({tag, "_busy"}, 32'(bus_if.busy), 32'd1);
    for (int k = 1; k < LAT; k++) begin
      chk({tag, "_early"}, 32'(bus_if.data_valid), 32'd0);
      @(posedge clk); #1;
    end
    chk({tag, "_valid"}, 32'(bus_if.data_valid), 32'd1);
    chk({tag, "_data"}, 32'(bus_if.data_out), 32'(exp));
    chk({tag, "_raddr"}, 32'(bus_if.resp_addr), 32'(a));
`ifdef MEM_RESP_ALIGN_CHECK_EN
    chk({tag, "_aerr"}, 32'(bus_if.align_err), 32'd0);
`endif
    @(posedge clk); #1;
    chk({tag, "_after"}, {bus_if.data_out, 15'd0, bus_if.data_valid}, 32'd0);
    chk({tag, "_idle"}, 32'(bus_if.busy), 32'd0);
  endtask

  initial begin
    bus_if.enable  = 1'b0;
    bus_if.wr      = 1'b0;
    bus_if.addr    = '0;
    bus_if.data_in = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus_if.data_valid), 32'd0);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_data", 32'(bus_if.data_out), 32'd0);
    chk("rst_raddr", 32'(bus_if.resp_addr), 32'd0);
    rst = 1'b0;

    do_write(16'h0000, 16'h1111);
    do_write(16'h0002, 16'h2222);
    do_write(16'h0004, 16'h3333);
    do_write(16'h0006, 16'h4444);
    do_write(16'h0012, 16'h7777);
    do_write(16'h0020, 16'h0A0A);

    // Write then read same word on the next cycle.
    do_write(16'h0010, 16'hBEEF);
    rd_chk("wr_rd", 16'h0010, 16'hBEEF);

    // Four back-to-back reads.
    for (int i = 0; i < 4; i++) begin
      bus_if.enable = 1'b1;
      bus_if.wr     = 1'b0;
      bus_if.addr   = 16'(2 * i);
      @(posedge clk); #1;
      chk("b2b_busy", 32'(bus_if.busy), 32'd1);
    end
    bus_if.enable = 1'b0;
    chk("b2b_v0", 32'(bus_if.data_valid), 32'd1);
    chk("b2b_d0", 32'(bus_if.data_out), 32'h1111);
    @(posedge clk); #1;
    chk("b2b_d1", {bus_if.resp_addr, bus_if.data_out}, 32'h0002_2222);
    @(posedge clk); #1;
    chk("b2b_d2", {bus_if.resp_addr, bus_if.data_out}, 32'h0004_3333);
    @(posedge clk); #1;
    chk("b2b_d3", {bus_if.resp_addr, bus_if.data_out}, 32'h0006_4444);
    chk("b2b_busy3", {15'd0, bus_if.busy, 15'd0, bus_if.data_valid}, 32'h0001_0001);
    @(posedge clk); #1;
    chk("b2b_end", {15'd0, bus_if.busy, 15'd0, bus_if.data_valid}, 32'd0);

    // Read then write same word: read returns old data.
    bus_if.enable = 1'b1;
    bus_if.wr     = 1'b0;
    bus_if.addr   = 16'h0020;
    @(posedge clk); #1;
    bus_if.wr      = 1'b1;
    bus_if.data_in = 16'h5555;
    @(posedge clk); #1;
    bus_if.enable = 1'b0;
    chk("rw_early1", 32'(bus_if.data_valid), 32'd0);
    @(posedge clk); #1;
    chk("rw_early2", 32'(bus_if.data_valid), 32'd0);
    @(posedge clk); #1;
    chk("rw_valid", 32'(bus_if.data_valid), 32'd1);
    chk("rw_old", 32'(bus_if.data_out), 32'h0A0A);
    @(posedge clk); #1;
    rd_chk("rw_new", 16'h0020, 16'h5555);

    // Address wrap modulo DEPTH_WORDS.
    rd_chk("wrap", 16'h0800, 16'h1111);

    // Reset with two reads in flight; request during reset is ignored.
    bus_if.enable = 1'b1;
    bus_if.wr     = 1'b0;
    bus_if.addr   = 16'h0000;
    @(posedge clk); #1;
    bus_if.addr   = 16'h0002;
    @(posedge clk); #1;
    bus_if.wr      = 1'b1;
    bus_if.addr    = 16'h0004;
    bus_if.data_in = 16'hDEAD;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus_if.enable = 1'b0;
    chk("rstf_busy", 32'(bus_if.busy), 32'd0);
    chk("rstf_out", {bus_if.resp_addr, bus_if.data_out}, 32'd0);
    pulses = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus_if.data_valid) pulses++;
    end
    chk("rstf_pulses", 32'(pulses), 32'd0);
    rd_chk("rstf_w4", 16'h0004, 16'h3333);
    rd_chk("rstf_w0", 16'h0000, 16'h1111);
    rd_chk("rstf_w2", 16'h0002, 16'h2222);

`ifdef MEM_RESP_ALIGN_CHECK_EN
    do_read(16'h0011);
    repeat (LAT - 1) begin
      @(posedge clk); #1;
    end
    chk("al_rd_valid", 32'(bus_if.data_valid), 32'd1);
    chk("al_rd_err", 32'(bus_if.align_err), 32'd1);
    chk("al_rd_raddr", 32'(bus_if.resp_addr), 32'h0011);
    chk("al_rd_data", 32'(bus_if.data_out), 32'hBEEF);
    @(posedge clk); #1;
    chk("al_rd_clr", 32'(bus_if.align_err), 32'd0);
    do_write(16'h0013, 16'h1234);
    chk("al_wr_err", 32'(bus_if.align_err), 32'd1);
    @(posedge clk); #1;
    chk("al_wr_clr", 32'(bus_if.align_err), 32'd0);
    rd_chk("al_wr_keep", 16'h0012, 16'h7777);
`else
    // Odd byte addresses alias to their word.
    rd_chk("odd_rd", 16'h0801, 16'h1111);
    do_write(16'h0031, 16'h9999);
    rd_chk("odd_wr", 16'h0030, 16'h9999);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
